// File: rtl/curveball_pkg.sv
// Shared data-memory constants and the read-return owner encoding.
package curveball_pkg;

    localparam int DMEM_ADDR_W       = 14;
    localparam int DMEM_DATA_W       = 16;
    localparam int CPU_BURST_MAX_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_GFX  = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / GFX) arbiter onto one single-port data SRAM.
// Same-cycle grant, 1-cycle read return; CPU priority bounded by a starvation counter.
module dmem_arbiter
    import curveball_pkg::*;
#(
    parameter int ADDR_W        = DMEM_ADDR_W,
    parameter int DATA_W        = DMEM_DATA_W,
    parameter int CPU_BURST_MAX = CPU_BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              gfx_req,
    input  logic              gfx_we,
    input  logic [ADDR_W-1:0] gfx_addr,
    input  logic [DATA_W-1:0] gfx_wdata,
    output logic              gfx_gnt,
    output logic              gfx_rvalid,
    output logic [DATA_W-1:0] gfx_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(CPU_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_BURST_MAX);

    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    owner_t           owner, owner_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            owner      <= OWN_NONE;
        end else begin
            starve_cnt <= starve_nxt;
            owner      <= owner_nxt;
        end
    end

    always_comb begin
        cpu_gnt    = 1'b0;
        gfx_gnt    = 1'b0;
        starve_nxt = '0;
        owner_nxt  = OWN_NONE;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        // Grants are forced low while reset is held, not just the state.
        if (!rst) begin
            if (cpu_req && (!gfx_req || starve_cnt != CNT_MAX))
                cpu_gnt = 1'b1;
            else if (gfx_req)
                gfx_gnt = 1'b1;
        end

        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            owner_nxt = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (gfx_gnt) begin
            mem_we    = gfx_we;
            mem_addr  = gfx_addr;
            mem_wdata = gfx_wdata;
            owner_nxt = gfx_we ? OWN_NONE : OWN_GFX;
        end

        // Counts CPU wins while GFX is waiting; any GFX win or GFX idle resets it.
        if (gfx_req && cpu_gnt)
            starve_nxt = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
    end

    assign mem_en     = cpu_gnt | gfx_gnt;
    assign cpu_stall  = cpu_req & ~cpu_gnt & ~rst;

    assign cpu_rvalid = (owner == OWN_CPU);
    assign gfx_rvalid = (owner == OWN_GFX);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign gfx_rdata  = gfx_rvalid ? mem_rdata : '0;

endmodule
